// File: rtl/clken_gen.sv
// Clock-enable generator: free-run or debounced single-step CPU enables with halt handling.
// Latency: clken 1 cycle after run/step request in IDLE; outputs registered; no backpressure.
module clken_gen #(
  parameter int DIV = 8,
  parameter int DEB = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        run,
  input  logic        step_btn,
  input  logic        halt,
  output logic        clken,
  output logic        clken_oop,
  output logic        busy,
  output logic [15:0] cycles
);

  localparam int PW = $clog2(DIV);
  localparam int CW = (DEB > 2) ? $clog2(DEB) : 1;
  localparam logic [PW-1:0] PH_LAST     = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_PRE_HALF = PW'(DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

  state_t          state;
  logic [PW-1:0]   ph;
  logic [1:0]      sync_q;
  logic            deb_lvl;
  logic [CW-1:0]   deb_cnt;
  logic            step_req;
  logic            fire;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_q  <= '0;
      deb_lvl <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync_q <= {sync_q[0], step_btn};
      if (sync_q[1] != deb_lvl) begin
        if (deb_cnt == CW'(DEB - 1)) begin
          deb_lvl <= sync_q[1];
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Rising edge of the debounced level, seen in the cycle it is about to be committed.
  assign step_req = sync_q[1] & ~deb_lvl & (deb_cnt == CW'(DEB - 1));

  assign fire = ((state == IDLE) && !halt && (run || step_req)) ||
                ((state == RUN) && (ph == PH_LAST) && !halt && run);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= IDLE;
      ph        <= '0;
      clken     <= 1'b0;
      clken_oop <= 1'b0;
      busy      <= 1'b0;
    end else begin
      clken     <= fire;
      clken_oop <= 1'b0;
      unique case (state)
        IDLE: begin
          ph <= '0;
          if (fire) begin
            state <= run ? RUN : STEP;
            busy  <= 1'b1;
          end
        end
        RUN, STEP: begin
          if (ph == PH_LAST) begin
            ph <= '0;
            if (halt) begin
              state <= HALTED;
              busy  <= 1'b0;
            end else if (!fire) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            ph        <= ph + 1'b1;
            clken_oop <= (ph == PH_PRE_HALF);
          end
        end
        HALTED: begin
          ph <= '0;
          if (!halt) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ph    <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      cycles <= '0;
    end else if (fire && (cycles != 16'hFFFF)) begin
      cycles <= cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_clken_gen.sv
// Self-checking bench for clken_gen (DIV=8, DEB=4) against a period-position model.
module tb_clken_gen;

  localparam int DIV = 8;
  localparam int DEB = 4;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt = 1'b0;
  logic        clken;
  logic        clken_oop;
  logic        busy;
  logic [15:0] cycles;

  int n_chk = 0;
  int n_fail = 0;

  clken_gen #(.DIV(DIV), .DEB(DEB)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .run      (run),
    .step_btn (step_btn),
    .halt     (halt),
    .clken    (clken),
    .clken_oop(clken_oop),
    .busy     (busy),
    .cycles   (cycles)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position inside the current enable period (-1 = none), plus halted flag.
  int          m_pos = -1;
  bit          m_is_step = 0;
  bit          m_halted = 0;
  bit [15:0]   m_cyc = 0;
  bit          m_s1 = 0, m_s2 = 0, m_deb = 0;
  bit          m_hist[$];

  always @(posedge sysclk) begin
    bit req;
    bit all_diff;
    if (reset) begin
      m_pos = -1; m_is_step = 0; m_halted = 0; m_cyc = 0;
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_hist = {};
    end else begin
      req = 0;
      m_hist.push_back(m_s2);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      all_diff = (m_hist.size() == DEB);
      foreach (m_hist[i]) if (m_hist[i] == m_deb) all_diff = 0;
      if (all_diff) begin
        m_deb = ~m_deb;
        req = m_deb;
        m_hist = {};
      end
      m_s2 = m_s1;
      m_s1 = step_btn;

      if (m_halted) begin
        if (!halt) m_halted = 0;
      end else if (m_pos < 0) begin
        if (!halt && run) begin
          m_pos = 0; m_is_step = 0;
        end else if (!halt && req) begin
          m_pos = 0; m_is_step = 1;
        end
      end else if (m_pos == DIV - 1) begin
        if (halt) begin
          m_pos = -1; m_halted = 1;
        end else if (!m_is_step && run) begin
          m_pos = 0;
        end else begin
          m_pos = -1;
        end
      end else begin
        m_pos++;
      end
      if (m_pos == 0 && m_cyc != 16'hFFFF) m_cyc++;
    end
  end

  always @(negedge sysclk) begin
    chk("clken", int'(clken), int'(m_pos == 0));
    chk("clken_oop", int'(clken_oop), int'(m_pos == DIV / 2));
    chk("busy", int'(busy), int'(m_pos >= 0));
    chk("cycles", int'(cycles), int'(m_cyc));
    chk("exclusive", int'(clken & clken_oop), 0);
  end

  int w_clk, w_oop, w_busy;

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic win(input int n);
    for (int i = 0; i < n; i++) begin
      tick(1);
      w_clk  += int'(clken);
      w_oop  += int'(clken_oop);
      w_busy += int'(busy);
    end
  endtask

  task automatic wclear();
    w_clk = 0; w_oop = 0; w_busy = 0;
  endtask

  initial begin
    tick(3);
    chk("rst_clken", int'(clken), 0);
    chk("rst_oop", int'(clken_oop), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cycles", int'(cycles), 0);

    // Free run from reset.
    reset = 1'b0;
    run   = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick(1);
      if (c == 1 || c == 9 || c == 17) chk($sformatf("run_clken_c%0d", c), int'(clken), 1);
      if (c == 2) chk("run_clken_c2", int'(clken), 0);
      if (c == 5 || c == 13) chk($sformatf("run_oop_c%0d", c), int'(clken_oop), 1);
      if (c == 24) chk("run_cycles_3", int'(cycles), 3);
    end
    run = 1'b0;
    tick(10);

    // Single step with bounce.
    wclear();
    step_btn = 1'b1; win(1);
    step_btn = 1'b0; win(1);
    step_btn = 1'b1; win(11);
    step_btn = 1'b0; win(20);
    chk("bounce_clken", w_clk, 1);
    chk("bounce_oop", w_oop, 1);
    chk("bounce_busy", w_busy, 8);
    chk("bounce_cycles", int'(cycles), 5);

    // Second press lands while the step is still in progress.
    wclear();
    step_btn = 1'b1; win(4);
    step_btn = 1'b0; win(4);
    step_btn = 1'b1; win(10);
    step_btn = 1'b0; win(20);
    chk("busy_step_clken", w_clk, 1);
    chk("busy_step_oop", w_oop, 1);
    chk("busy_step_cycles", int'(cycles), 6);

    // Halt mid-period.
    wclear();
    run = 1'b1; win(4);
    halt = 1'b1; win(10);
    chk("halt_clken", w_clk, 1);
    chk("halt_oop", w_oop, 1);
    chk("halt_busy", int'(busy), 0);
    halt = 1'b0;
    tick(1);
    chk("halt_exit_idle", int'(clken), 0);
    tick(1);
    chk("halt_resume", int'(clken), 1);
    run = 1'b0;
    tick(12);

    // Reset mid-run at ph==2, with the button already held.
    run = 1'b1;
    tick(3);
    reset = 1'b1;
    step_btn = 1'b1;
    tick(1);
    chk("midrst_clken", int'(clken), 0);
    chk("midrst_oop", int'(clken_oop), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cycles", int'(cycles), 0);
    wclear();
    win(3);
    chk("midrst_no_oop", w_oop, 0);

    // Button held across reset release yields one step.
    run = 1'b0;
    reset = 1'b0;
    wclear();
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      w_clk += int'(clken);
      if (c == 5) chk("held_btn_c5", int'(clken), 0);
      if (c == 6) chk("held_btn_c6", int'(clken), 1);
    end
    chk("held_btn_count", w_clk, 1);
    step_btn = 1'b0;
    tick(10);

    // Saturation: preload near the top, then run several periods.
    force dut.cycles = 16'hFFFE;
    m_cyc = 16'hFFFE;
    tick(1);
    release dut.cycles;
    tick(2);
    chk("sat_preload", int'(cycles), 16'hFFFE);
    run = 1'b1;
    tick(1);
    chk("sat_reach", int'(cycles), 16'hFFFF);
    tick(24);
    chk("sat_hold", int'(cycles), 16'hFFFF);
    run = 1'b0;
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
